// File: rtl/instr_rom_fetch_if.sv
// Fetch port bundle for instr_rom_fetch.
// master = program counter side, slave = instruction store.
interface instr_rom_fetch_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_oob;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_oob
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_oob
    );
endinterface

// File: rtl/instr_rom_fetch.sv
// Instruction store with a registered valid/ready fetch port, 1-cycle latency.
// Define PROG_LOAD_EN for a reloadable register array with a write port.
module instr_rom_fetch #(
    parameter int unsigned       ADDR_W       = 4,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       DEPTH        = 16,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PROG_LOAD_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    instr_rom_fetch_if.slave  bus
);

    function automatic logic [DATA_W-1:0] boot_word(input int unsigned idx);
        logic [7:0] b;
        b = 8'h00;
        unique case (idx)
            0:       b = 8'h01;
            1:       b = 8'h11;
            2:       b = 8'h21;
            3:       b = 8'h31;
            4:       b = 8'hC4;
            5:       b = 8'hC8;
            6:       b = 8'hCC;
            7:       b = 8'h40;
            default: b = 8'h00;
        endcase
        if (idx < 8) return DATA_W'(b);
        return DEFAULT_WORD;
    endfunction

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_oob_q;
    logic              accept;
    logic              oob_now;
    logic [DATA_W-1:0] rd_word;

    assign bus.req_ready = !rsp_valid_q | bus.rsp_ready;
    assign accept        = bus.req_valid & bus.req_ready;
    assign oob_now       = 32'(bus.req_addr) >= DEPTH;

`ifdef PROG_LOAD_EN
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_ok;

    assign rd_idx = bus.req_addr[IDX_W-1:0];
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign wr_ok  = wr_en && (32'(wr_addr) < DEPTH);

    // The output register samples mem_q before this edge's write lands,
    // so a same-cycle write and fetch returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= boot_word(unsigned'(i));
            end
        end else if (wr_ok) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_word = DEFAULT_WORD;
        if (!oob_now) rd_word = mem_q[rd_idx];
    end
`else
    always_comb begin
        rd_word = DEFAULT_WORD;
        if (!oob_now) rd_word = boot_word(32'(bus.req_addr));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DEFAULT_WORD;
            rsp_oob_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_word;
            rsp_oob_q   <= oob_now;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_oob   = rsp_oob_q;

endmodule

// File: tb/tb_instr_rom_fetch.sv
// Directed bench for instr_rom_fetch: a DEPTH=16 and a DEPTH=8 instance.
// The DEPTH=8 instance uses DEFAULT_WORD=EE so out-of-range data is visible.
module tb_instr_rom_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] boot [8];

    instr_rom_fetch_if #(.ADDR_W(4), .DATA_W(8)) bus16 ();
    instr_rom_fetch_if #(.ADDR_W(4), .DATA_W(8)) bus8 ();

`ifdef PROG_LOAD_EN
    logic       wr_en16, wr_en8;
    logic [3:0] wr_addr16, wr_addr8;
    logic [7:0] wr_data16, wr_data8;
`endif

    instr_rom_fetch #(
        .ADDR_W(4), .DATA_W(8), .DEPTH(16), .DEFAULT_WORD(8'h00)
    ) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef PROG_LOAD_EN
        .wr_en   (wr_en16),
        .wr_addr (wr_addr16),
        .wr_data (wr_data16),
`endif
        .bus     (bus16)
    );

    instr_rom_fetch #(
        .ADDR_W(4), .DATA_W(8), .DEPTH(8), .DEFAULT_WORD(8'hEE)
    ) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef PROG_LOAD_EN
        .wr_en   (wr_en8),
        .wr_addr (wr_addr8),
        .wr_data (wr_data8),
`endif
        .bus     (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        boot[0] = 8'h01; boot[1] = 8'h11; boot[2] = 8'h21; boot[3] = 8'h31;
        boot[4] = 8'hC4; boot[5] = 8'hC8; boot[6] = 8'hCC; boot[7] = 8'h40;

        rst_n = 1'b0;
        bus16.req_valid = 1'b0; bus16.req_addr = '0; bus16.rsp_ready = 1'b1;
        bus8.req_valid  = 1'b0; bus8.req_addr  = '0; bus8.rsp_ready  = 1'b1;
`ifdef PROG_LOAD_EN
        wr_en16 = 1'b0; wr_addr16 = '0; wr_data16 = '0;
        wr_en8  = 1'b0; wr_addr8  = '0; wr_data8  = '0;
`endif
        #12;
        check("rst_valid", 32'(bus16.rsp_valid), 0);
        check("rst_data",  32'(bus16.rsp_data), 32'h00);
        check("rst_oob",   32'(bus16.rsp_oob), 0);
        check("rst_data8", 32'(bus8.rsp_data), 32'hEE);
        check("rst_ready", 32'(bus16.req_ready), 1);

        // Test 1: back-to-back fetch 0..7
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus16.req_valid = 1'b1;
            bus16.req_addr  = 4'(i);
            tick();
            check($sformatf("b2b_valid%0d", i), 32'(bus16.rsp_valid), 1);
            check($sformatf("b2b_data%0d", i), 32'(bus16.rsp_data),
                  32'(boot[i]));
            check($sformatf("b2b_ready%0d", i), 32'(bus16.req_ready), 1);
        end
        bus16.req_valid = 1'b0;
        tick();
        check("drain_valid", 32'(bus16.rsp_valid), 0);
        check("drain_keep",  32'(bus16.rsp_data), 32'h40);

        // Test 2: fetch 4, stall 3 cycles with a competing request pending
        bus16.req_valid = 1'b1;
        bus16.req_addr  = 4'd4;
        bus16.rsp_ready = 1'b0;
        tick();
        check("stall_first", 32'(bus16.rsp_data), 32'hC4);
        bus16.req_addr = 4'd2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_ready%0d", i), 32'(bus16.req_ready), 0);
            check($sformatf("stall_data%0d", i), 32'(bus16.rsp_data), 32'hC4);
            check($sformatf("stall_valid%0d", i), 32'(bus16.rsp_valid), 1);
            tick();
        end
        bus16.req_valid = 1'b0;
        bus16.rsp_ready = 1'b1;
        #1;
        check("release_ready", 32'(bus16.req_ready), 1);
        tick();
        check("release_valid", 32'(bus16.rsp_valid), 0);
        check("release_keep",  32'(bus16.rsp_data), 32'hC4);

        // Test 3: addr 9 in range for DEPTH=16, out of range for DEPTH=8
        bus16.req_valid = 1'b1; bus16.req_addr = 4'd9;
        bus8.req_valid  = 1'b1; bus8.req_addr  = 4'd9;
        tick();
        check("a9_d16_data", 32'(bus16.rsp_data), 32'h00);
        check("a9_d16_oob",  32'(bus16.rsp_oob), 0);
        check("a9_d8_data",  32'(bus8.rsp_data), 32'hEE);
        check("a9_d8_oob",   32'(bus8.rsp_oob), 1);
        bus16.req_valid = 1'b0;
        bus8.req_addr   = 4'd7;
        tick();
        check("a7_d8_data", 32'(bus8.rsp_data), 32'h40);
        check("a7_d8_oob",  32'(bus8.rsp_oob), 0);
        bus8.req_addr = 4'd8;
        tick();
        check("a8_d8_data", 32'(bus8.rsp_data), 32'hEE);
        check("a8_d8_oob",  32'(bus8.rsp_oob), 1);
        bus8.req_addr = 4'd15;
        tick();
        check("a15_d8_oob", 32'(bus8.rsp_oob), 1);
        bus8.req_valid = 1'b0;
        tick();

        // Test 4: asynchronous reset in the middle of a stall
        bus16.req_valid = 1'b1;
        bus16.req_addr  = 4'd5;
        bus16.rsp_ready = 1'b0;
        tick();
        bus16.req_valid = 1'b0;
        check("pre_rst_data", 32'(bus16.rsp_data), 32'hC8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus16.rsp_valid), 0);
        check("async_data",  32'(bus16.rsp_data), 32'h00);
        check("async_oob",   32'(bus16.rsp_oob), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus16.rsp_ready = 1'b1;
        bus16.req_valid = 1'b1;
        bus16.req_addr  = 4'd0;
        tick();
        check("post_rst_data", 32'(bus16.rsp_data), 32'h01);
        bus16.req_valid = 1'b0;
        tick();

`ifdef PROG_LOAD_EN
        // Test 5: write/fetch collision returns the old word
        wr_en16 = 1'b1; wr_addr16 = 4'd3; wr_data16 = 8'hA5;
        bus16.req_valid = 1'b1; bus16.req_addr = 4'd3;
        tick();
        wr_en16 = 1'b0;
        check("rbw_old", 32'(bus16.rsp_data), 32'h31);
        tick();
        check("rbw_new", 32'(bus16.rsp_data), 32'hA5);
        bus16.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus16.req_valid = 1'b1;
        tick();
        check("reload_boot", 32'(bus16.rsp_data), 32'h31);
        bus16.req_valid = 1'b0;

        // Test 6: out-of-range write on DEPTH=8 must not alias
        wr_en8 = 1'b1; wr_addr8 = 4'd15; wr_data8 = 8'hFF;
        tick();
        wr_en8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus8.req_valid = 1'b1;
            bus8.req_addr  = 4'(i);
            tick();
            check($sformatf("oobwr_data%0d", i), 32'(bus8.rsp_data),
                  32'(boot[i]));
        end
        bus8.req_valid = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
